// File: rtl/dragon_shot_move_collision_pkg.sv
// Shared types and constants for the enemy shot mover: FSM states,
// one-hot direction codes, the fixed-point shift and the aiming rule.
package dragon_shot_pkg;

   localparam int FIXED_POINT_SHIFT = 6;

   localparam logic [2:0] DIR_RIGHT = 3'b001;
   localparam logic [2:0] DIR_DOWN  = 3'b010;
   localparam logic [2:0] DIR_LEFT  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLYING   = 2'd1,
      ST_HIT      = 2'd2,
      ST_COOLDOWN = 2'd3
   } shot_state_e;

   // Player inside the deadband around the shooter gets a straight shot.
   function automatic logic [2:0] aim_dir(
      input logic signed [10:0] player_x,
      input logic signed [10:0] dragon_x,
      input int                 deadband
   );
      int p;
      int d;
      p = int'(player_x);
      d = int'(dragon_x);
      if (p < d - deadband) begin
         return DIR_LEFT;
      end
      if (p > d + deadband) begin
         return DIR_RIGHT;
      end
      return DIR_DOWN;
   endfunction

endpackage

// File: rtl/dragon_shot_move_collision_if.sv
// Signal bundle between the enemy AI / collision logic (master) and the
// enemy shot mover (slave).
interface dragon_shot_move_collision_if;
   import dragon_shot_pkg::*;

   // Signalling contract: fireRequest is sampled every cycle and accepted only
   // while the mover is idle and not paused; there is no ready/ack, so a request
   // made while busy is simply dropped. Collisions are levels, startOfFrame is a
   // one-cycle pulse, playerHit is a one-cycle pulse per shot.
   logic               startOfFrame;
   logic               pause;
   logic               fireRequest;
   logic signed [10:0] dragon_topLeftX;
   logic signed [10:0] dragon_topLeftY;
   logic signed [10:0] player_topLeftX;
   logic               shotPlayerCollision;
   logic               shotBoxCollision;

   logic               shotActive;
   logic               busy;
   logic               playerHit;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic [2:0]         draw_shot_dir;
   shot_state_e        dbg_state;

   modport master (
      output startOfFrame, pause, fireRequest,
      output dragon_topLeftX, dragon_topLeftY, player_topLeftX,
      output shotPlayerCollision, shotBoxCollision,
      input  shotActive, busy, playerHit, topLeftX, topLeftY, draw_shot_dir,
      input  dbg_state
   );

   modport slave (
      input  startOfFrame, pause, fireRequest,
      input  dragon_topLeftX, dragon_topLeftY, player_topLeftX,
      input  shotPlayerCollision, shotBoxCollision,
      output shotActive, busy, playerHit, topLeftX, topLeftY, draw_shot_dir,
      output dbg_state
   );

endinterface

// File: rtl/dragon_shot_move_collision_shot_frame_timer.sv
// Loadable frame down-counter shared by the HIT hold and the COOLDOWN wait.
// o_done fires on the tick that completes the loaded count (0 acts like 1).
module shot_frame_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_tick,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_done = i_tick && (r_count <= CNT_W'(1));

endmodule

// File: rtl/dragon_shot_move_collision.sv
// Enemy shot mover: spawns below the dragon, aims at the player, advances one
// fixed-point step per frame and retires on collision or leaving the playfield.
module dragon_shot_move_collision
   import dragon_shot_pkg::*;
#(
   parameter int FIXED_POINT_MULTIPLIER = 64,
   parameter int DOWN_SPEED             = 90,
   parameter int ANGLED_DOWN_SPEED      = 64,
   parameter int LATERAL_SPEED          = 32,
   parameter int AIM_DEADBAND           = 16,
   parameter int SPAWN_OFFSET_Y         = 24,
   parameter int BOTTOM_LIMIT           = 470,
   parameter int X_MIN                  = 1,
   parameter int X_MAX                  = 639,
   parameter int HIT_HOLD_FRAMES        = 8,
   parameter int COOLDOWN_FRAMES        = 20,
   parameter int PARK_FP                = 50_000
) (
   input logic                         clk,
   input logic                         reset,
   dragon_shot_move_collision_if.slave bus
);

   localparam int CNT_W = 8;

   localparam logic signed [31:0] PARK        = 32'(PARK_FP);
   localparam logic signed [31:0] BOTTOM_FP   = 32'(BOTTOM_LIMIT * FIXED_POINT_MULTIPLIER);
   localparam logic signed [31:0] XMIN_FP     = 32'(X_MIN * FIXED_POINT_MULTIPLIER);
   localparam logic signed [31:0] XMAX_FP     = 32'(X_MAX * FIXED_POINT_MULTIPLIER);
   localparam logic signed [31:0] STEP_DOWN   = 32'(DOWN_SPEED);
   localparam logic signed [31:0] STEP_ANGLED = 32'(ANGLED_DOWN_SPEED);
   localparam logic signed [31:0] STEP_LAT    = 32'(LATERAL_SPEED);

   shot_state_e        r_state;
   shot_state_e        w_state_nx;
   logic signed [31:0] r_x_fp;
   logic signed [31:0] r_y_fp;
   logic signed [31:0] w_x_nx;
   logic signed [31:0] w_y_nx;
   logic [2:0]         r_dir;
   logic [2:0]         w_dir_nx;
   logic               r_player_hit;
   logic               w_hit_nx;

   logic               w_tick;
   logic               w_load;
   logic [CNT_W-1:0]   w_load_val;
   logic               w_timer_done;
   logic               w_retire;
   logic signed [31:0] w_step_x;
   logic signed [31:0] w_step_y;
   logic signed [31:0] w_mv_x;
   logic signed [31:0] w_mv_y;
   logic signed [31:0] w_spawn_x;
   logic signed [31:0] w_spawn_y;

   assign w_tick    = bus.startOfFrame && !bus.pause;
   assign w_spawn_x = 32'(bus.dragon_topLeftX) * FIXED_POINT_MULTIPLIER;
   assign w_spawn_y = (32'(bus.dragon_topLeftY) + SPAWN_OFFSET_Y) * FIXED_POINT_MULTIPLIER;

   always_comb begin
      w_step_x = '0;
      w_step_y = STEP_DOWN;
      if (r_dir == DIR_RIGHT) begin
         w_step_x = STEP_LAT;
         w_step_y = STEP_ANGLED;
      end else if (r_dir == DIR_LEFT) begin
         w_step_x = -STEP_LAT;
         w_step_y = STEP_ANGLED;
      end
   end

   assign w_mv_x   = r_x_fp + w_step_x;
   assign w_mv_y   = r_y_fp + w_step_y;
   assign w_retire = (w_mv_y > BOTTOM_FP) || (w_mv_x < XMIN_FP) || (w_mv_x > XMAX_FP);

   shot_frame_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_load_val(w_load_val),
      .i_tick    (w_tick),
      .o_done    (w_timer_done)
   );

   // Player collision outranks box collision, which outranks the frame move.
   always_comb begin
      w_state_nx = r_state;
      w_x_nx     = r_x_fp;
      w_y_nx     = r_y_fp;
      w_dir_nx   = r_dir;
      w_hit_nx   = 1'b0;
      w_load     = 1'b0;
      w_load_val = '0;
      unique case (r_state)
         ST_IDLE: begin
            w_x_nx = PARK;
            w_y_nx = PARK;
            if (bus.fireRequest && !bus.pause) begin
               w_x_nx     = w_spawn_x;
               w_y_nx     = w_spawn_y;
               w_dir_nx   = aim_dir(bus.player_topLeftX, bus.dragon_topLeftX, AIM_DEADBAND);
               w_state_nx = ST_FLYING;
            end
         end
         ST_FLYING: begin
            if (bus.shotPlayerCollision) begin
               w_hit_nx   = 1'b1;
               w_load     = 1'b1;
               w_load_val = CNT_W'(HIT_HOLD_FRAMES);
               w_state_nx = ST_HIT;
            end else if (bus.shotBoxCollision || (w_tick && w_retire)) begin
               w_x_nx     = PARK;
               w_y_nx     = PARK;
               w_load     = 1'b1;
               w_load_val = CNT_W'(COOLDOWN_FRAMES);
               w_state_nx = ST_COOLDOWN;
            end else if (w_tick) begin
               w_x_nx = w_mv_x;
               w_y_nx = w_mv_y;
            end
         end
         ST_HIT: begin
            if (w_timer_done) begin
               w_x_nx     = PARK;
               w_y_nx     = PARK;
               w_load     = 1'b1;
               w_load_val = CNT_W'(COOLDOWN_FRAMES);
               w_state_nx = ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            if (w_timer_done) begin
               w_state_nx = ST_IDLE;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_x_fp       <= PARK;
         r_y_fp       <= PARK;
         r_dir        <= DIR_DOWN;
         r_player_hit <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_x_fp       <= w_x_nx;
         r_y_fp       <= w_y_nx;
         r_dir        <= w_dir_nx;
         r_player_hit <= w_hit_nx;
      end
   end

   assign bus.shotActive    = (r_state == ST_FLYING) || (r_state == ST_HIT);
   assign bus.busy          = (r_state != ST_IDLE);
   assign bus.playerHit     = r_player_hit;
   assign bus.topLeftX      = 11'(r_x_fp >>> FIXED_POINT_SHIFT);
   assign bus.topLeftY      = 11'(r_y_fp >>> FIXED_POINT_SHIFT);
   assign bus.draw_shot_dir = r_dir;
   assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_dragon_shot_move_collision.sv
// Bench for the enemy shot mover: directed scenarios plus random traffic, each
// cycle's expected outputs come from a pixel/frame level model of the shot.
module tb_dragon_shot_move_collision;
   import dragon_shot_pkg::*;

   localparam int FPM   = 64;
   localparam int DOWN  = 90;
   localparam int ANG   = 64;
   localparam int LAT   = 32;
   localparam int DB    = 16;
   localparam int SOFF  = 24;
   localparam int BOT   = 470;
   localparam int XMIN  = 1;
   localparam int XMAX  = 639;
   localparam int HOLD  = 8;
   localparam int CD    = 20;
   localparam int PARK  = 50_000;

   typedef struct packed {
      logic        act;
      logic        busy;
      logic        hit;
      logic [10:0] x;
      logic [10:0] y;
      logic [2:0]  dir;
      logic [1:0]  st;
   } snap_t;

   localparam int SW = $bits(snap_t);

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dragon_shot_move_collision_if bus();

   dragon_shot_move_collision #(
      .FIXED_POINT_MULTIPLIER(FPM), .DOWN_SPEED(DOWN), .ANGLED_DOWN_SPEED(ANG),
      .LATERAL_SPEED(LAT), .AIM_DEADBAND(DB), .SPAWN_OFFSET_Y(SOFF),
      .BOTTOM_LIMIT(BOT), .X_MIN(XMIN), .X_MAX(XMAX),
      .HIT_HOLD_FRAMES(HOLD), .COOLDOWN_FRAMES(CD), .PARK_FP(PARK)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [SW-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   int dx = 0;
   int dy = 0;
   int px = 0;

   // Reference model: shot as pixel-scaled integers and a frame tally per phase.
   shot_state_e m_phase = ST_IDLE;
   int          m_x     = PARK;
   int          m_y     = PARK;
   logic [2:0]  m_dir   = DIR_DOWN;
   int          m_ticks = 0;

   function automatic void m_retire();
      m_x     = PARK;
      m_y     = PARK;
      m_phase = ST_COOLDOWN;
      m_ticks = 0;
   endfunction

   function automatic void model_step(input logic rst, input logic fire, input logic sof,
                                      input logic pse, input logic pc, input logic bc,
                                      output logic hit);
      int nx;
      int ny;
      hit = 1'b0;
      if (rst) begin
         m_phase = ST_IDLE;
         m_x     = PARK;
         m_y     = PARK;
         m_dir   = DIR_DOWN;
         m_ticks = 0;
      end else begin
         case (m_phase)
            ST_IDLE: if (fire && !pse) begin
               m_x = dx * FPM;
               m_y = (dy + SOFF) * FPM;
               if (px < dx - DB)      m_dir = DIR_LEFT;
               else if (px > dx + DB) m_dir = DIR_RIGHT;
               else                   m_dir = DIR_DOWN;
               m_phase = ST_FLYING;
            end
            ST_FLYING: begin
               if (pc) begin
                  hit     = 1'b1;
                  m_phase = ST_HIT;
                  m_ticks = 0;
               end else if (bc) begin
                  m_retire();
               end else if (sof && !pse) begin
                  nx = m_x + ((m_dir == DIR_RIGHT) ? LAT : (m_dir == DIR_LEFT) ? -LAT : 0);
                  ny = m_y + ((m_dir == DIR_DOWN) ? DOWN : ANG);
                  if (ny > BOT * FPM || nx < XMIN * FPM || nx > XMAX * FPM) m_retire();
                  else begin
                     m_x = nx;
                     m_y = ny;
                  end
               end
            end
            ST_HIT: if (sof && !pse) begin
               m_ticks++;
               if (m_ticks >= HOLD) m_retire();
            end
            default: if (sof && !pse) begin
               m_ticks++;
               if (m_ticks >= CD) m_phase = ST_IDLE;
            end
         endcase
      end
   endfunction

   function automatic snap_t model_snap(input logic hit);
      snap_t s;
      s.act  = (m_phase == ST_FLYING) || (m_phase == ST_HIT);
      s.busy = (m_phase != ST_IDLE);
      s.hit  = hit;
      s.x    = 11'(m_x / FPM);
      s.y    = 11'(m_y / FPM);
      s.dir  = m_dir;
      s.st   = m_phase;
      return s;
   endfunction

   // Driver: one call = one clock cycle of inputs; expected result is queued.
   task automatic cyc(input logic rst, input logic fire, input logic sof,
                      input logic pse, input logic pc, input logic bc);
      logic hit;
      @(negedge clk);
      reset                   = rst;
      bus.fireRequest         = fire;
      bus.startOfFrame        = sof;
      bus.pause               = pse;
      bus.shotPlayerCollision = pc;
      bus.shotBoxCollision    = bc;
      bus.dragon_topLeftX     = 11'(dx);
      bus.dragon_topLeftY     = 11'(dy);
      bus.player_topLeftX     = 11'(px);
      model_step(rst, fire, sof, pse, pc, bc, hit);
      exp_q.push_back(model_snap(hit));
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic fire();
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame(input logic pse);
      cyc(1'b0, 1'b0, 1'b1, pse, 1'b0, 1'b0);
      idle();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: every registered cycle compares the DUT against the queued snapshot.
   always @(posedge clk) begin
      snap_t e;
      snap_t a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.shotActive, bus.busy, bus.playerHit, bus.topLeftX, bus.topLeftY,
              bus.draw_shot_dir, bus.dbg_state};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle_out t=%0t got act=%b busy=%b hit=%b x=%0d y=%0d dir=%b st=%0d expected act=%b busy=%b hit=%b x=%0d y=%0d dir=%b st=%0d",
                     $time, a.act, a.busy, a.hit, a.x, a.y, a.dir, a.st,
                     e.act, e.busy, e.hit, e.x, e.y, e.dir, e.st);
         end
      end
   end

   int aim_px[4]  = '{316, 317, 283, 284};
   int aim_exp[4] = '{2, 1, 4, 2};

   initial begin
      bus.startOfFrame        = 1'b0;
      bus.pause               = 1'b0;
      bus.fireRequest         = 1'b0;
      bus.shotPlayerCollision = 1'b0;
      bus.shotBoxCollision    = 1'b0;
      bus.dragon_topLeftX     = '0;
      bus.dragon_topLeftY     = '0;
      bus.player_topLeftX     = '0;

      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      settle();
      chk("rst_x", int'(bus.topLeftX), 781);
      chk("rst_y", int'(bus.topLeftY), 781);
      chk("rst_dir", int'(bus.draw_shot_dir), 2);
      chk("rst_busy", int'(bus.busy), 0);

      // Aim deadband edges around dragon X = 300.
      dx = 300;
      dy = 50;
      for (int i = 0; i < 4; i++) begin
         px = aim_px[i];
         fire();
         settle();
         chk("aim_dir", int'(bus.draw_shot_dir), aim_exp[i]);
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      idle();

      // Straight shot: spawn, first frame, fly to the bottom, cooldown.
      px = 305;
      fire();
      settle();
      chk("spawn_act", int'(bus.shotActive), 1);
      chk("spawn_x", int'(bus.topLeftX), 300);
      chk("spawn_y", int'(bus.topLeftY), 74);
      chk("spawn_dir", int'(bus.draw_shot_dir), 2);
      frame(1'b0);
      settle();
      chk("frame1_y", int'(bus.topLeftY), 75);
      for (int i = 0; i < 400 && m_phase == ST_FLYING; i++) frame(1'b0);
      settle();
      chk("bottom_park_x", int'(bus.topLeftX), 781);
      chk("bottom_busy", int'(bus.busy), 1);
      px = 20;
      fire();
      for (int i = 0; i < 3; i++) frame(1'b1);
      frames(19);
      settle();
      chk("cool19_busy", int'(bus.busy), 1);
      frame(1'b0);
      settle();
      chk("cool20_busy", int'(bus.busy), 0);

      // Left shot, pause in flight, then a held player collision.
      px = 100;
      fire();
      frames(10);
      settle();
      chk("left10_x", int'(bus.topLeftX), 295);
      for (int i = 0; i < 3; i++) frame(1'b1);
      settle();
      chk("pause_x", int'(bus.topLeftX), 295);
      chk("pause_y", int'(bus.topLeftY), 84);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      chk("hit_pulse", int'(bus.playerHit), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      chk("hit_once", int'(bus.playerHit), 0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      frames(7);
      settle();
      chk("hold7_act", int'(bus.shotActive), 1);
      chk("hold7_x", int'(bus.topLeftX), 295);
      frame(1'b0);
      settle();
      chk("hold8_act", int'(bus.shotActive), 0);
      chk("hold8_x", int'(bus.topLeftX), 781);
      frames(20);

      // Box collision on a frame edge: no move, straight to cooldown.
      dx = 200;
      dy = 100;
      px = 200;
      fire();
      frames(2);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      settle();
      chk("box_state", int'(bus.dbg_state), int'(ST_COOLDOWN));
      chk("box_park_y", int'(bus.topLeftY), 781);
      frames(20);

      // Asynchronous reset mid-flight.
      px = 20;
      fire();
      frames(3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("areset_act", int'(bus.shotActive), 0);
      chk("areset_x", int'(bus.topLeftX), 781);
      chk("areset_dir", int'(bus.draw_shot_dir), 2);
      idle();

      // Random traffic across all states.
      for (int i = 0; i < 4000; i++) begin
         dx = $urandom_range(0, 639);
         dy = $urandom_range(0, 440);
         px = $urandom_range(0, 639);
         cyc(($urandom_range(0, 799) == 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 59) == 0));
      end
      idle();
      idle();
      settle();
      settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
